// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: ALU operator codes, default widths,
// the hard-wired zero register index, and a shift-operator classifier.
package alu_issue_stage_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam int ISSUE_X0           = 0;

  localparam logic [3:0] ALU_OPERATOR_ADD  = 4'd0;
  localparam logic [3:0] ALU_OPERATOR_SUB  = 4'd1;
  localparam logic [3:0] ALU_OPERATOR_AND  = 4'd2;
  localparam logic [3:0] ALU_OPERATOR_OR   = 4'd3;
  localparam logic [3:0] ALU_OPERATOR_XOR  = 4'd4;
  localparam logic [3:0] ALU_OPERATOR_SLL  = 4'd5;
  localparam logic [3:0] ALU_OPERATOR_SRL  = 4'd6;
  localparam logic [3:0] ALU_OPERATOR_SRA  = 4'd7;
  localparam logic [3:0] ALU_OPERATOR_SLT  = 4'd8;
  localparam logic [3:0] ALU_OPERATOR_SLTU = 4'd9;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_OPERATOR_SLL) || (op == ALU_OPERATOR_SRL) || (op == ALU_OPERATOR_SRA);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Operand resolve: picks the EX result, then the MEM result, then the base value
// for a register index. Register x0 is never forwarded.
module alu_fwd_mux
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [XLEN-1:0]       base,
  input  logic                  fwd_ex_valid,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]       fwd_ex_data,
  input  logic                  fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  output logic [XLEN-1:0]       result
);

  // NOTE: assign a default before any condition so no path leaves result
  // unassigned; that keeps this purely combinational with no inferred latch.
  always_comb begin
    result = base;
    if (idx != REG_ADDR_W'(ISSUE_X0)) begin
      if (fwd_ex_valid && (fwd_ex_rd == idx)) begin
        result = fwd_ex_data;
      end else if (fwd_mem_valid && (fwd_mem_rd == idx)) begin
        result = fwd_mem_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: main + skid entry with operand forwarding at capture and
// while held. Define SHAMT_MASK_EN to clamp shift operand2 to bits [4:0].
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_operator,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic                  in_use_imm,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  fwd_ex_valid,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]       fwd_ex_data,
  input  logic                  fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_operator,
  output logic [XLEN-1:0]       out_operand1,
  output logic [XLEN-1:0]       out_operand2,
  output logic [REG_ADDR_W-1:0] out_rd
);

  typedef struct packed {
    logic                  valid;
    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       opnd1;
    logic [XLEN-1:0]       opnd2;
  } entry_t;

  entry_t main_q, skid_q;
  entry_t shared_e, main_ref;

  // Capture and skid refresh never coincide (in_ready is low whenever skid is
  // valid), so one resolver pair serves both and the other pair serves main.
  logic                  sel_skid;
  logic [REG_ADDR_W-1:0] a_idx1, a_idx2;
  logic [XLEN-1:0]       a_base1, a_base2, a_res1, a_res2;
  logic [XLEN-1:0]       m_res1, m_res2;

  assign sel_skid = skid_q.valid;
  assign a_idx1   = sel_skid ? skid_q.rs1   : in_rs1;
  assign a_idx2   = sel_skid ? skid_q.rs2   : in_rs2;
  assign a_base1  = sel_skid ? skid_q.opnd1 : in_rs1_data;
  assign a_base2  = sel_skid ? skid_q.opnd2 : in_rs2_data;

  alu_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a_rs1 (
    .idx(a_idx1), .base(a_base1),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .result(a_res1)
  );

  alu_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a_rs2 (
    .idx(a_idx2), .base(a_base2),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .result(a_res2)
  );

  alu_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_m_rs1 (
    .idx(main_q.rs1), .base(main_q.opnd1),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .result(m_res1)
  );

  alu_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_m_rs2 (
    .idx(main_q.rs2), .base(main_q.opnd2),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .result(m_res2)
  );

  // shared_e: the refreshed skid entry when skid is valid, else the new capture.
  always_comb begin
    if (sel_skid) begin
      shared_e       = skid_q;
      shared_e.opnd2 = skid_q.use_imm ? skid_q.opnd2 : a_res2;
    end else begin
      shared_e.valid   = 1'b1;
      shared_e.op      = in_operator;
      shared_e.rs1     = in_rs1;
      shared_e.rs2     = in_rs2;
      shared_e.use_imm = in_use_imm;
      shared_e.rd      = in_rd;
      shared_e.opnd2   = in_use_imm ? in_imm : a_res2;
    end
    shared_e.opnd1 = a_res1;
`ifdef SHAMT_MASK_EN
    if (is_shift(shared_e.op)) begin
      shared_e.opnd2 = {{(XLEN-5){1'b0}}, shared_e.opnd2[4:0]};
    end
`endif

    main_ref       = main_q;
    main_ref.opnd1 = m_res1;
    main_ref.opnd2 = main_q.use_imm ? main_q.opnd2 : m_res2;
`ifdef SHAMT_MASK_EN
    if (is_shift(main_q.op)) begin
      main_ref.opnd2 = {{(XLEN-5){1'b0}}, main_ref.opnd2[4:0]};
    end
`endif
  end

  logic accept, main_drain;
  assign in_ready   = !skid_q.valid;
  assign accept     = in_valid && in_ready;
  assign main_drain = main_q.valid && out_ready;

  // NOTE: payload fields are reset too, not just valid, because the outputs
  // are required to read zero out of reset.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else if (skid_q.valid) begin
      if (main_drain) begin
        main_q       <= shared_e;
        skid_q.valid <= 1'b0;
      end else begin
        main_q <= main_ref;
        skid_q <= shared_e;
      end
    end else if (accept) begin
      if (!main_q.valid || main_drain) begin
        main_q <= shared_e;
      end else begin
        main_q <= main_ref;
        skid_q <= shared_e;
      end
    end else if (main_drain) begin
      main_q.valid <= 1'b0;
    end else if (main_q.valid) begin
      main_q <= main_ref;
    end
  end

  assign out_valid    = main_q.valid;
  assign out_operator = main_q.op;
  assign out_operand1 = main_q.opnd1;
  assign out_operand2 = main_q.opnd2;
  assign out_rd       = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_operator;
  logic [RW-1:0]   in_rs1, in_rs2, in_rd;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic            in_use_imm;
  logic            fwd_ex_valid, fwd_mem_valid;
  logic [RW-1:0]   fwd_ex_rd, fwd_mem_rd;
  logic [XLEN-1:0] fwd_ex_data, fwd_mem_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_operator;
  logic [XLEN-1:0] out_operand1, out_operand2;
  logic [RW-1:0]   out_rd;

  alu_issue_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_operator(in_operator),
    .in_rs1(in_rs1), .in_rs1_data(in_rs1_data), .in_rs2(in_rs2), .in_rs2_data(in_rs2_data),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rd(in_rd),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_operator(out_operator),
    .out_operand1(out_operand1), .out_operand2(out_operand2), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RW-1:0]   rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef SHAMT_MASK_EN
  localparam logic [XLEN-1:0] SHAMT_25 = 32'h0000_0005;
`else
  localparam logic [XLEN-1:0] SHAMT_25 = 32'h0000_0025;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every accepted output must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got op %0h opnd1 %0h rd %0h, expected nothing",
                 out_operator, out_operand1, out_rd);
      end else begin
        e = sb.pop_front();
        check("out_operator", 64'(out_operator), 64'(e.op));
        check("out_operand1", 64'(out_operand1), 64'(e.a));
        check("out_operand2", 64'(out_operand2), 64'(e.b));
        check("out_rd",       64'(out_rd),       64'(e.rd));
      end
    end
  end

  task automatic expect_op(input logic [3:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [RW-1:0] rd);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [RW-1:0] rs1, input logic [XLEN-1:0] d1,
                       input logic [RW-1:0] rs2, input logic [XLEN-1:0] d2, input logic use_imm,
                       input logic [XLEN-1:0] imm, input logic [RW-1:0] rd);
    in_operator = op; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_use_imm = use_imm; in_imm = imm; in_rd = rd; in_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic wait_accept(input string name);
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: accept timeout, got in_ready=0, expected 1 within 20 cycles", name);
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
    fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    clear_fwd();
    drive(ALU_OPERATOR_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, '0, 5'd3);

    // Reset with in_valid high
    @(negedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_operand1",  64'(out_operand1), 64'd0);
    check("reset_rd",        64'(out_rd), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1; in_valid = 1'b0;
    step(1);

    // Basic issue, one-cycle latency
    drive(ALU_OPERATOR_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, '0, 5'd9);
    expect_op(ALU_OPERATOR_ADD, 32'd5, 32'd7, 5'd9);
    wait_accept("basic");
    @(negedge clk);
    check("basic_out_valid", 64'(out_valid), 64'd1);
    check("basic_operand1",  64'(out_operand1), 64'd5);
    step(1);

    // EX beats MEM on the same rd
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'hAA;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hBB;
    drive(ALU_OPERATOR_ADD, 5'd3, 32'h11, 5'd5, 32'h22, 1'b0, '0, 5'd10);
    expect_op(ALU_OPERATOR_ADD, 32'hAA, 32'h22, 5'd10);
    wait_accept("fwd_ex_prio");
    clear_fwd();

    // x0 never forwarded
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd0; fwd_ex_data = 32'hCC;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'hDD;
    drive(ALU_OPERATOR_OR, 5'd0, 32'h33, 5'd0, 32'h44, 1'b0, '0, 5'd11);
    expect_op(ALU_OPERATOR_OR, 32'h33, 32'h44, 5'd11);
    wait_accept("fwd_x0");
    clear_fwd();

    // MEM-only match on rs1, EX-only match on rs2
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd6; fwd_mem_data = 32'h66;
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd7; fwd_ex_data = 32'h77;
    drive(ALU_OPERATOR_XOR, 5'd6, 32'h1, 5'd7, 32'h2, 1'b0, '0, 5'd12);
    expect_op(ALU_OPERATOR_XOR, 32'h66, 32'h77, 5'd12);
    wait_accept("fwd_mixed");
    clear_fwd();

    // Immediate overrides a forwardable rs2
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'h99;
    drive(ALU_OPERATOR_AND, 5'd3, 32'h5, 5'd3, 32'h8, 1'b1, 32'hFFFF_FFF0, 5'd13);
    expect_op(ALU_OPERATOR_AND, 32'h99, 32'hFFFF_FFF0, 5'd13);
    wait_accept("imm");
    clear_fwd();
    step(2);

    // Backpressure: two accepted, third stalls, order kept
    out_ready = 1'b0;
    drive(ALU_OPERATOR_SUB, 5'd1, 32'hA1, 5'd2, 32'hA2, 1'b0, '0, 5'd1);
    expect_op(ALU_OPERATOR_SUB, 32'hA1, 32'hA2, 5'd1);
    wait_accept("bp_a");
    drive(ALU_OPERATOR_SUB, 5'd1, 32'hB1, 5'd2, 32'hB2, 1'b0, '0, 5'd2);
    expect_op(ALU_OPERATOR_SUB, 32'hB1, 32'hB2, 5'd2);
    wait_accept("bp_b");
    @(negedge clk);
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    drive(ALU_OPERATOR_SUB, 5'd1, 32'hC1, 5'd2, 32'hC2, 1'b0, '0, 5'd3);
    expect_op(ALU_OPERATOR_SUB, 32'hC1, 32'hC2, 5'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_stall_in_ready", 64'(in_ready), 64'd0);
      check("bp_stall_operand1", 64'(out_operand1), 64'hA1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("bp_c");
    step(3);

    // Refresh of a stalled entry from a one-cycle MEM pulse
    out_ready = 1'b0;
    drive(ALU_OPERATOR_SUB, 5'd1, 32'h1, 5'd4, 32'h10, 1'b0, '0, 5'd7);
    expect_op(ALU_OPERATOR_SUB, 32'h1, 32'h20, 5'd7);
    wait_accept("refresh");
    @(negedge clk);
    check("refresh_before", 64'(out_operand2), 64'h10);
    @(posedge clk); #1;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h20;
    @(posedge clk); #1;
    clear_fwd();
    @(negedge clk);
    check("refresh_after", 64'(out_operand2), 64'h20);
    repeat (2) @(negedge clk);
    check("refresh_sticky", 64'(out_operand2), 64'h20);
    check("refresh_valid",  64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(2);

    // Flush with both entries full and input offered
    out_ready = 1'b0;
    drive(ALU_OPERATOR_ADD, 5'd1, 32'hD1, 5'd2, 32'hD2, 1'b0, '0, 5'd20);
    wait_accept("flush_d");
    drive(ALU_OPERATOR_ADD, 5'd1, 32'hE1, 5'd2, 32'hE2, 1'b0, '0, 5'd21);
    wait_accept("flush_e");
    @(negedge clk);
    check("flush_full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    drive(ALU_OPERATOR_ADD, 5'd1, 32'hF1, 5'd2, 32'hF2, 1'b0, '0, 5'd22);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready), 64'd1);

    // Flush drops a same-cycle handshake
    @(posedge clk); #1;
    drive(ALU_OPERATOR_ADD, 5'd1, 32'h61, 5'd2, 32'h62, 1'b0, '0, 5'd23);
    wait_accept("flush_g");
    drive(ALU_OPERATOR_ADD, 5'd1, 32'h71, 5'd2, 32'h72, 1'b0, '0, 5'd24);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(4);

    // Shift-amount handling
    drive(ALU_OPERATOR_SLL, 5'd1, 32'h3, 5'd0, 32'h0, 1'b1, 32'h25, 5'd14);
    expect_op(ALU_OPERATOR_SLL, 32'h3, SHAMT_25, 5'd14);
    wait_accept("sll_imm");
    drive(ALU_OPERATOR_SRA, 5'd2, 32'h8000_0000, 5'd5, 32'h25, 1'b0, '0, 5'd15);
    expect_op(ALU_OPERATOR_SRA, 32'h8000_0000, SHAMT_25, 5'd15);
    wait_accept("sra_reg");
    drive(ALU_OPERATOR_ADD, 5'd1, 32'h1, 5'd0, 32'h0, 1'b1, 32'h25, 5'd16);
    expect_op(ALU_OPERATOR_ADD, 32'h1, 32'h25, 5'd16);
    wait_accept("add_imm");
    step(4);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID->EX pipeline stage directly upstream of the ALU. Accepts decoded ALU ops from decode over a valid/ready handshake and resolves register operands by forwarding from the EX and MEM result buses. Presents registered operator/operand1/operand2 to the ALU and its consumer. A 2-entry skid buffer decouples decode from downstream backpressure without a combinational ready path.

Parameters:
XLEN, 32, operand/result width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  async active-low reset
flush  in  1  sync kill of all held entries (branch redirect)
in_valid  in  1  decode has an op
in_ready  out  1  stage can accept
in_operator  in  4  ALU_OPERATOR_* code
in_rs1  in  REG_ADDR_W  source 1 index
in_rs1_data  in  XLEN  register-file value for rs1
in_rs2  in  REG_ADDR_W  source 2 index
in_rs2_data  in  XLEN  register-file value for rs2
in_use_imm  in  1  operand2 = in_imm instead of rs2
in_imm  in  XLEN  sign-extended immediate
in_rd  in  REG_ADDR_W  destination index
fwd_ex_valid  in  1  EX result bus valid
fwd_ex_rd  in  REG_ADDR_W  EX destination
fwd_ex_data  in  XLEN  EX result
fwd_mem_valid  in  1  MEM result bus valid
fwd_mem_rd  in  REG_ADDR_W  MEM destination
fwd_mem_data  in  XLEN  MEM result
out_valid  out  1  op presented to ALU
out_ready  in  1  downstream accepts
out_operator  out  4  to ALU operator
out_operand1  out  XLEN  to ALU operand1
out_operand2  out  XLEN  to ALU operand2
out_rd  out  REG_ADDR_W  destination, carried alongside

Behaviour:
- Reset (rstn=0, async): both entries invalid; out_valid=0, in_ready=1; out_operator/operands/out_rd=0.
- Storage: main entry (drives out_*) and skid entry. Each holds valid, operator, rs1, rs2, use_imm, rd, operand1, operand2.
- in_ready = !skid_valid (registered only, no combinational path from out_ready).
- Capture on in_valid&&in_ready: if main empty or main draining (out_ready), load main; else load skid. On main drain with skid valid, skid -> main and skid cleared the same cycle; simultaneous input then loads skid.
- Forwarding resolve f(idx, base): idx==0 -> base (x0 never forwarded); fwd_ex_valid&&fwd_ex_rd==idx -> fwd_ex_data; else fwd_mem_valid&&fwd_mem_rd==idx -> fwd_mem_data; else base. EX beats MEM.
- Applied at capture: operand1=f(in_rs1,in_rs1_data); operand2=use_imm ? in_imm : f(in_rs2,in_rs2_data).
- Held refresh: every cycle an entry stays valid and is not replaced, operand1 <= f(rs1, operand1), operand2 <= use_imm ? operand2 : f(rs2, operand2). Covers producers that retire while stalled.
- Latency: accept at edge N -> out_valid at N+1 (1 cycle), operands as resolved at N.
- Full: both entries valid -> in_ready=0; decode must hold inputs stable.
- flush=1: both entries invalidated at the next edge; a same-cycle input handshake is dropped; in_ready=1 next cycle. Flush wins over every other event.
- out_* hold stable while out_valid&&!out_ready, except operand refresh from forwarding.
- Reset mid-operation: entries discarded immediately, no drain.

Optional Feature:
SHAMT_MASK_EN: when defined, for ALU_OPERATOR_SLL/SRL/SRA, out_operand2 is masked to bits [4:0] (upper bits 0) at capture and refresh, giving RV32 shift-amount semantics. When undefined, operand2 passes unmasked.

Decomposition:
- ALU_OPERATOR_* codes stay in include/define.v. Add REG_ADDR_W default and an ISSUE_X0 constant there.
- One natural sub-module: alu_fwd_mux (combinational resolve f), instantiated 4 times (capture rs1/rs2, refresh per entry and operand shares instances via muxing).

Test Plan:
- Reset with in_valid=1 -> out_valid=0, in_ready=1. After release, ADD rs1=1(data 5) rs2=2(data 7) -> next cycle out_operand1=5, operand2=7, out_valid=1.
- fwd_ex rd=3 data 0xAA and fwd_mem rd=3 data 0xBB, issue rs1=3 -> operand1=0xAA. Repeat with rs1=0 and ex rd=0 -> operand1=in_rs1_data.
- out_ready=0 for 3 cycles with 3 ops offered -> 2 accepted, in_ready=0 after second. Release -> order preserved, no loss or duplicate.
- Stalled main entry rs2=4 holding 0x10. fwd_mem rd=4 data 0x20 pulses 1 cycle -> out_operand2 becomes 0x20 and stays.
- Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped op never appears.
- SHAMT_MASK_EN defined: SLL operand2=0x25 -> out_operand2=0x05. Undefined -> 0x25.
